ft245_rx_framer: RTL and testbench

- Sits on the ftdi_clk side of the FT245 host interface, between the FT245 synchronous read engine and the inbound async FIFO.
- Consumes the raw received byte stream and hunts for a frame header: sync byte, then a 3-byte big-endian length.
- Forwards only payload bytes to the FIFO, tagged with start-of-frame and end-of-frame.
- Reports sync errors, inter-byte timeouts and completed frames.

---
 rtl/ft245_rx_framer.sv | 116 +++++++++++
 tb/tb_ft245_rx_framer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_rx_framer.sv
// ft245_rx_framer: hunts a sync byte plus a 24-bit length header in the FT245 receive stream and forwards only payload bytes, tagged with sof/eof
module ft245_rx_framer #(
    parameter logic [7:0] SYNC_BYTE    = 8'hCD,
    parameter int         IDLE_TIMEOUT = 1024
) (
    input  logic        ftdi_clk,
    input  logic        rst,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic [7:0]  o_out_data,
    output logic        o_out_sof,
    output logic        o_out_eof,
    output logic        o_out_wr,
    input  logic        i_out_full,
    output logic        o_frame_active,
    output logic [23:0] o_frame_len,
    output logic        o_err_sync,
    output logic        o_err_timeout,
    output logic [15:0] o_frame_count
);
    typedef enum logic [2:0] {HUNT, LEN2, LEN1, LEN0, PAYLOAD} state_t;

    localparam logic [15:0] TMO_LAST = 16'(IDLE_TIMEOUT - 1);

    state_t      r_state;
    logic [24:0] r_rem;
    logic [15:0] r_tmo;
    logic        r_first;
    logic [7:0]  r_data;
    logic        r_sof;
    logic        r_eof;
    logic        r_wr;
    logic [23:0] r_len;
    logic        r_err_sync;
    logic        r_err_tmo;
    logic [15:0] r_count;
    logic        w_acc;

    assign o_in_ready     = (r_state == PAYLOAD) ? !i_out_full : 1'b1;
    assign w_acc          = i_in_valid && o_in_ready;
    assign o_frame_active = r_state != HUNT;
    assign o_out_data     = r_data;
    assign o_out_sof      = r_sof;
    assign o_out_eof      = r_eof;
    assign o_out_wr       = r_wr;
    assign o_frame_len    = r_len;
    assign o_err_sync     = r_err_sync;
    assign o_err_timeout  = r_err_tmo;
    assign o_frame_count  = r_count;

    // Header/payload state machine with registered FIFO write port and idle-timeout abort; an acceptance always beats an expiring timeout
    always_ff @(posedge ftdi_clk) begin
        if (rst) begin
            r_state    <= HUNT;
            r_rem      <= '0;
            r_tmo      <= '0;
            r_first    <= 1'b0;
            r_data     <= '0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_wr       <= 1'b0;
            r_len      <= '0;
            r_err_sync <= 1'b0;
            r_err_tmo  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_wr       <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_err_sync <= 1'b0;
            r_err_tmo  <= 1'b0;
            case (r_state)
                HUNT: if (w_acc) begin
                    if (i_in_data == SYNC_BYTE) r_state <= LEN2;
                    else r_err_sync <= 1'b1;
                end
                LEN2: if (w_acc) begin
                    r_len[23:16] <= i_in_data;
                    r_state      <= LEN1;
                end
                LEN1: if (w_acc) begin
                    r_len[15:8] <= i_in_data;
                    r_state     <= LEN0;
                end
                LEN0: if (w_acc) begin
                    r_len[7:0] <= i_in_data;
                    r_rem      <= 25'({r_len[23:8], i_in_data}) + 25'd1;
                    r_first    <= 1'b1;
                    r_state    <= PAYLOAD;
                end
                PAYLOAD: if (w_acc) begin
                    r_data  <= i_in_data;
                    r_wr    <= 1'b1;
                    r_sof   <= r_first;
                    r_first <= 1'b0;
                    r_eof   <= r_rem == 25'd1;
                    r_rem   <= r_rem - 25'd1;
                    if (r_rem == 25'd1) begin
                        r_state <= HUNT;
                        r_count <= r_count + 16'd1;
                    end
                end
                default: r_state <= HUNT;
            endcase
            if (r_state == HUNT || w_acc) r_tmo <= '0;
            else if (!i_in_valid) begin
                if (r_tmo == TMO_LAST) begin
                    r_err_tmo <= 1'b1;
                    r_state   <= HUNT;
                    r_tmo     <= '0;
                end else r_tmo <= r_tmo + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_ft245_rx_framer.sv
// tb_ft245_rx_framer: vector table plus hand sequences, with a scoreboard that expects every accepted byte's effect exactly one cycle later
module tb_ft245_rx_framer;
    logic        ftdi_clk = 1'b0;
    logic        rst      = 1'b1;
    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic        out_full = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_sof, out_eof, out_wr;
    logic        frame_active;
    logic [23:0] frame_len;
    logic        err_sync, err_timeout;
    logic [15:0] frame_count;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int tmo_cnt = 0;

    typedef struct {
        logic       pay;
        logic [7:0] d;
        logic       sof, eof, es;
        int         stamp;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        rs;
        logic [7:0]  d;
        logic        pay, sof, eof, es, chk;
        logic [15:0] cnt;
        logic [23:0] len;
    } vec_t;
    vec_t vt[15];

    ft245_rx_framer #(.SYNC_BYTE(8'hCD), .IDLE_TIMEOUT(16)) dut (
        .ftdi_clk      (ftdi_clk),
        .rst           (rst),
        .i_in_data     (in_data),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .o_out_data    (out_data),
        .o_out_sof     (out_sof),
        .o_out_eof     (out_eof),
        .o_out_wr      (out_wr),
        .i_out_full    (out_full),
        .o_frame_active(frame_active),
        .o_frame_len   (frame_len),
        .o_err_sync    (err_sync),
        .o_err_timeout (err_timeout),
        .o_frame_count (frame_count)
    );

    always #5 ftdi_clk = ~ftdi_clk;

    always @(posedge ftdi_clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    // Each accepted byte must show its write/err_sync exactly one cycle later; anything else is spurious
    always @(negedge ftdi_clk) begin : mon
        exp_t e;
        if (err_timeout) tmo_cnt++;
        if (sb.size() > 0 && sb[0].stamp == cyc - 1) begin
            e = sb.pop_front();
            chk("out_next_cycle", {out_wr, out_wr ? out_data : 8'h00, out_sof, out_eof, err_sync},
                {e.pay, e.pay ? e.d : 8'h00, e.sof, e.eof, e.es});
        end else begin
            chk("no_spurious", {out_wr, err_sync}, 2'b00);
        end
    end

    function automatic vec_t v(logic rs, logic [7:0] d, logic pay, logic sof, logic eof, logic es,
                               logic c, logic [15:0] cnt, logic [23:0] len);
        v.rs = rs; v.d = d; v.pay = pay; v.sof = sof; v.eof = eof; v.es = es;
        v.chk = c; v.cnt = cnt; v.len = len;
    endfunction

    task automatic send(input logic [7:0] d, input logic pay, input logic sof, input logic eof, input logic es);
        exp_t e;
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge ftdi_clk);
        while (!in_ready && n < 100) begin
            @(negedge ftdi_clk);
            n++;
        end
        chk("accept_wait", {63'b0, in_ready}, 64'd1);
        e.pay = pay; e.d = d; e.sof = sof; e.eof = eof; e.es = es; e.stamp = cyc;
        if (in_ready) sb.push_back(e);
        @(posedge ftdi_clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic hdr(input logic [23:0] len);
        send(8'hCD, 0, 0, 0, 0);
        send(len[23:16], 0, 0, 0, 0);
        send(len[15:8], 0, 0, 0, 0);
        send(len[7:0], 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        repeat (2) @(negedge ftdi_clk);
        @(posedge ftdi_clk);
        #1 in_valid = 1'b0;
        rst = 1'b1;
        @(posedge ftdi_clk);
        #1 rst = 1'b0;
    endtask

    task automatic post_check(input string n, input logic [15:0] cnt, input logic [23:0] len);
        repeat (2) @(negedge ftdi_clk);
        chk({n, "_count_len"}, {frame_count, frame_len}, {cnt, len});
        chk({n, "_sb_empty"}, sb.size(), 0);
        @(posedge ftdi_clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string n);
        chk(n, {in_ready, out_data, out_sof, out_eof, out_wr, frame_active, frame_len, err_sync,
                err_timeout, frame_count}, {1'b1, 54'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        vt[0]  = v(1, 8'hCD, 0, 0, 0, 0, 0, 0, 0);
        vt[1]  = v(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        vt[2]  = v(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        vt[3]  = v(0, 8'h03, 0, 0, 0, 0, 0, 0, 0);
        vt[4]  = v(0, 8'h11, 1, 1, 0, 0, 0, 0, 0);
        vt[5]  = v(0, 8'h22, 1, 0, 0, 0, 0, 0, 0);
        vt[6]  = v(0, 8'h33, 1, 0, 0, 0, 0, 0, 0);
        vt[7]  = v(0, 8'h44, 1, 0, 1, 0, 1, 16'd1, 24'h000003);
        vt[8]  = v(1, 8'h55, 0, 0, 0, 1, 0, 0, 0);
        vt[9]  = v(0, 8'hAA, 0, 0, 0, 1, 0, 0, 0);
        vt[10] = v(0, 8'hCD, 0, 0, 0, 0, 0, 0, 0);
        vt[11] = v(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        vt[12] = v(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        vt[13] = v(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        vt[14] = v(0, 8'h77, 1, 1, 1, 0, 1, 16'd1, 24'h000000);

        repeat (3) @(posedge ftdi_clk);
        #1 rst = 1'b0;
        @(negedge ftdi_clk);
        chk_reset_vals("reset_values");
        @(posedge ftdi_clk);
        #1;

        foreach (vt[i]) begin
            if (vt[i].rs) do_reset();
            send(vt[i].d, vt[i].pay, vt[i].sof, vt[i].eof, vt[i].es);
            if (vt[i].chk) post_check($sformatf("vec%0d", i), vt[i].cnt, vt[i].len);
        end

        do_reset();
        t0 = tmo_cnt;
        hdr(24'h000007);
        send(8'h10, 1, 1, 0, 0);
        send(8'h11, 1, 0, 0, 0);
        send(8'h12, 1, 0, 0, 0);
        out_full = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h13;
        @(negedge ftdi_clk);
        chk("full_ready_low", {63'b0, in_ready}, 64'd0);
        fork
            begin
                repeat (20) @(posedge ftdi_clk);
                #1 out_full = 1'b0;
            end
        join_none
        send(8'h13, 1, 0, 0, 0);
        send(8'h14, 1, 0, 0, 0);
        send(8'h15, 1, 0, 0, 0);
        send(8'h16, 1, 0, 0, 0);
        send(8'h17, 1, 0, 1, 0);
        post_check("full", 16'd1, 24'h000007);
        chk("full_no_tmo", tmo_cnt - t0, 0);

        do_reset();
        t0 = tmo_cnt;
        hdr(24'h000009);
        send(8'hA1, 1, 1, 0, 0);
        send(8'hA2, 1, 0, 0, 0);
        repeat (16) @(negedge ftdi_clk);
        chk("tmo_before", {err_timeout, frame_active}, 2'b01);
        @(negedge ftdi_clk);
        chk("tmo_pulse", {err_timeout, frame_active, frame_count}, {1'b1, 1'b0, 16'd0});
        @(negedge ftdi_clk);
        chk("tmo_once", tmo_cnt - t0, 1);
        @(posedge ftdi_clk);
        #1;
        hdr(24'h000000);
        send(8'h5A, 1, 1, 1, 0);
        post_check("after_tmo", 16'd1, 24'h000000);

        do_reset();
        t0 = tmo_cnt;
        hdr(24'h000001);
        send(8'hB1, 1, 1, 0, 0);
        repeat (15) @(posedge ftdi_clk);
        #1;
        send(8'hB2, 1, 0, 1, 0);
        post_check("tmo_boundary", 16'd1, 24'h000001);
        chk("tmo_boundary_none", tmo_cnt - t0, 0);

        do_reset();
        hdr(24'h000004);
        send(8'hC1, 1, 1, 0, 0);
        send(8'hC2, 1, 0, 0, 0);
        rst = 1'b1;
        @(posedge ftdi_clk);
        #1 rst = 1'b0;
        @(negedge ftdi_clk);
        chk_reset_vals("midframe_reset");
        @(posedge ftdi_clk);
        #1;
        hdr(24'h000001);
        send(8'hAB, 1, 1, 0, 0);
        send(8'hCD, 1, 0, 1, 0);
        post_check("after_reset", 16'd1, 24'h000001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
